inverse_permute_collector: RTL
==============================

# inverse_permute_collector

Decoder-side counterpart of the 64-lane slice permutation datapath. It accepts 64 permuted 25-bit slices serially over a valid/ready stream and applies the inverse of the per-slice pi permutation, one slice per cycle. It buffers all 64 recovered slices, then drains them in index order over a second valid/ready stream. The block sits after the permutation stage and feeds the decoder's output writer.

## Interface
Parameters:
- SLICES, 64, number of slices per frame; the counter is $clog2(SLICES) bits wide.
- W, 25, slice width; fixed 5x5 plane, and no other value is supported.

Ports:
- clk  input  1  clock, all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; begins a frame; honoured only in IDLE or DONE.
- in_valid  input  1  input slice valid.
- in_data  input  25  permuted slice B.
- in_ready  output  1  high only in LOAD.
- out_valid  output  1  recovered slice valid.
- out_data  output  25  recovered slice A.
- out_idx  output  6  index of the slice on out_data.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in LOAD or DRAIN.
- all_done  output  1  high in DONE; held until the next accepted start.

## Operation
- Bit mapping:
  - Slice bit i = 5*y + x, with x, y in 0..4.
  - Inverse pi: A[x][y] = B[y][(2x+3y) mod 5].
  - This is pure wiring, computed combinationally on in_data.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start moves to LOAD and clears cnt.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes inv_pi(in_data) to buf[cnt] and increments cnt.
  - The handshake at cnt=63 moves to DRAIN, and cnt wraps to 0.
- DRAIN:
  - out_valid=1.
  - out_data=buf[cnt], out_idx=cnt.
  - Each out_valid&&out_ready handshake increments cnt.
  - The handshake at cnt=63 moves to DONE.
  - With out_ready low, out_data and out_idx hold stable.
- DONE:
  - all_done=1.
  - start clears all_done, clears cnt and moves to LOAD in the same edge.
- start is ignored in LOAD and DRAIN; a start pulse does not restart a frame.
- in_valid outside LOAD is ignored, and no buffer write occurs.
- Reset (any time, including mid-frame):
  - state=IDLE, cnt=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, all_done=0.
  - The buffer is not cleared; its contents are don't-care after reset.
- There is no back-pressure on LOAD: the buffer is never full before the 64th handshake.

## Timing
- Accept rate is one slice per cycle; drain rate is one slice per cycle while out_ready=1.
- A start edge gives in_ready=1 in the next cycle.
- After the 64th input handshake, out_valid=1 in the next cycle.
  - This is 1 cycle of latency; 2 cycles with DEPERM_OUT_REG_EN.
- After the 64th output handshake, all_done=1 in the next cycle.
- The minimum frame is 1 + 64 + 64 cycles from start to all_done, with continuous valid/ready.

## Configuration
- Macro: DEPERM_OUT_REG_EN.
- Defined:
  - out_data and out_idx come from a registered output stage with a one-entry skid buffer.
  - First out_valid is 2 cycles after the last input handshake.
  - Full one-per-cycle drain throughput is kept under any out_ready pattern.
  - Buffer read is registered and decoupled from the output path.
- Undefined:
  - out_data is a direct combinational read of buf[cnt].
  - Latency is 1 cycle.

## Structure
- Shared package (deperm_pkg):
  - SLICES and W constants.
  - State enum {IDLE, LOAD, DRAIN, DONE}.
  - Function inv_pi(logic [24:0]) returning logic [24:0].
- One sub-module: inv_pi_slice.
  - Combinational 25-bit wiring only.
  - Reused by the verification reference model.
- The top module holds the FSM, the counter, the 64x25 buffer and the optional output stage.

## Test plan
- Single-bit mapping:
  - Frame with every slice 25'h0000002 -> all 64 outputs 25'h0000040.
  - Frame with every slice 25'h0000020 -> all 64 outputs 25'h0000008.
  - Bit 0 maps to itself: 25'h0000001 -> 25'h0000001.
- Ordering:
  - Slice k = k (k = 0..63) fed without gaps -> out_idx sequence 0..63, out_data = inv_pi(k).
  - all_done rises exactly 129 cycles after start (130 with DEPERM_OUT_REG_EN).
- Back-pressure:
  - out_ready toggled 1,0,0,1 repeatedly during DRAIN -> out_data and out_idx stable while stalled.
  - No slice skipped or repeated; 64 handshakes total.
- Input gaps: in_valid low on every third cycle -> exactly 64 writes; DRAIN entered only after the 64th.
- Spurious start:
  - start pulsed at cnt=30 in LOAD and at cnt=10 in DRAIN -> no effect; frame completes normally.
  - start in DONE -> all_done=0 and in_ready=1 in the next cycle.
- Reset mid-frame: rst low for 1 cycle at cnt=40 of DRAIN:
  - Immediately: out_valid=0, all_done=0.
  - After release: state IDLE.
  - A fresh 64-slice frame completes correctly.

Source files
------------

// File: rtl/deperm_pkg.sv
// Shared constants, FSM state encoding and the inverse pi bit mapping
// for the inverse permutation collector.
package deperm_pkg;

    localparam int SLICES = 64;
    localparam int W      = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Slice bit i = 5*y + x; A[x][y] = B[y][(2x+3y) mod 5].
    function automatic logic [W-1:0] inv_pi(input logic [W-1:0] b);
        logic [W-1:0] a;
        a = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                a[5*y + x] = b[5*((2*x + 3*y) % 5) + y];
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/inv_pi_slice.sv
// Purely combinational inverse pi on one 25-bit (5x5) slice.
module inv_pi_slice
    import deperm_pkg::*;
(
    input  logic [W-1:0] slice_in,
    output logic [W-1:0] slice_out
);

    always_comb begin
        slice_out = inv_pi(slice_in);
    end

endmodule

// File: rtl/inverse_permute_collector.sv
// Collects 64 permuted slices, undoes pi on the way into the buffer, then drains in index order.
// Optional macro DEPERM_OUT_REG_EN: registered buffer read plus skid-buffered output stage.
module inverse_permute_collector #(
    parameter int SLICES = deperm_pkg::SLICES,
    parameter int W      = deperm_pkg::W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [W-1:0]              in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [W-1:0]              out_data,
    output logic [$clog2(SLICES)-1:0] out_idx,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      all_done
);

    import deperm_pkg::*;

    localparam int            CW   = $clog2(SLICES);
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  slice_buf [SLICES];
    logic [W-1:0]  recovered;
    logic          in_fire;
    logic          last_in;
    logic          out_fire;

    inv_pi_slice u_inv_pi (
        .slice_in  (in_data),
        .slice_out (recovered)
    );

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == DRAIN);
    assign all_done = (state == DONE);
    assign in_fire  = in_valid && in_ready;
    assign last_in  = in_fire && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts input writes in LOAD and output handshakes in DRAIN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
                    if (cnt == LAST) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (in_fire) slice_buf[cnt] <= recovered;
    end

`ifdef DEPERM_OUT_REG_EN

    logic [CW-1:0] rd_cnt;
    logic          rd_all;
    logic          rd_v;
    logic [W-1:0]  rd_q;
    logic [CW-1:0] rd_idx;
    logic          skid_v;
    logic [W-1:0]  skid_q;
    logic [CW-1:0] skid_idx;
    logic          out_v;
    logic [W-1:0]  out_q;
    logic [CW-1:0] oidx_q;
    logic          start_ok;
    logic          rd_take;
    logic          issue;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign rd_take  = rd_v && !skid_v;
    // Slice 0 is already in the buffer when slice 63 arrives, so the first read overlaps the last write.
    assign issue    = (last_in || ((state == DRAIN) && !rd_all)) && (!rd_v || rd_take);
    assign out_fire = out_v && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            rd_all <= 1'b0;
            rd_v   <= 1'b0;
            rd_q   <= '0;
            rd_idx <= '0;
        end else begin
            if (start_ok) begin
                rd_cnt <= '0;
                rd_all <= 1'b0;
            end else if (issue) begin
                rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + CW'(1);
                if (rd_cnt == LAST) rd_all <= 1'b1;
            end
            if (issue) begin
                rd_v   <= 1'b1;
                rd_q   <= slice_buf[rd_cnt];
                rd_idx <= rd_cnt;
            end else if (rd_take) begin
                rd_v <= 1'b0;
            end
        end
    end

    // The skid entry absorbs the slice in flight when out_ready drops, so ready never fans back combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v    <= 1'b0;
            out_q    <= '0;
            oidx_q   <= '0;
            skid_v   <= 1'b0;
            skid_q   <= '0;
            skid_idx <= '0;
        end else if (!out_v || out_fire) begin
            if (skid_v) begin
                out_v  <= 1'b1;
                out_q  <= skid_q;
                oidx_q <= skid_idx;
                skid_v <= 1'b0;
            end else if (rd_take) begin
                out_v  <= 1'b1;
                out_q  <= rd_q;
                oidx_q <= rd_idx;
            end else begin
                out_v <= 1'b0;
            end
        end else if (rd_take) begin
            skid_v   <= 1'b1;
            skid_q   <= rd_q;
            skid_idx <= rd_idx;
        end
    end

    assign out_valid = out_v;
    assign out_data  = out_q;
    assign out_idx   = oidx_q;

`else

    assign out_valid = (state == DRAIN);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = (state == DRAIN) ? slice_buf[cnt] : '0;
    assign out_idx   = (state == DRAIN) ? cnt : '0;

`endif

endmodule
